alu_reservation_station: RTL
============================

// Module: alu_reservation_station
// PURPOSE
// Tomasulo reservation station that schedules the shared ALU. It buffers decoded ALU, branch and jump
// ops from the dispatcher and snoops the ALU and LSB result broadcasts to wake pending operands.
// Each cycle it issues at most one fully-ready op to the ALU input registers.
// It sits between dispatch and ALU; ALU results return through the same broadcast path.
// PARAMETERS
// RS_SIZE    16  number of entries (power of two, >=2)
// RS_IDX_W   4   log2(RS_SIZE)
// ROB_POS_W  4   ROB tag width (matches `ROB_POS_WID)
// DATA_W     32  operand/result width (matches `DATA_WID, `ADDR_WID)
// PORTS
// clk            in   1        clock, rising edge
// rst            in   1        asynchronous reset, active-high
// rdy            in   1        global ready; low = freeze all state
// rollback       in   1        mispredict flush
// dsp_valid      in   1        dispatch new op this cycle
// dsp_opcode     in   7        opcode
// dsp_func3      in   3        func3 (instr[14:12])
// dsp_func7      in   1        instr[30]
// dsp_q1_busy    in   1        rs1 pending; tag in dsp_q1
// dsp_q1         in   ROB_POS_W  ROB tag producing rs1
// dsp_val1       in   DATA_W   rs1 value (valid when !dsp_q1_busy)
// dsp_q2_busy    in   1        rs2 pending (dispatcher drives 0 when rs2 unused)
// dsp_q2         in   ROB_POS_W  ROB tag producing rs2
// dsp_val2       in   DATA_W   rs2 value
// dsp_imm        in   DATA_W   sign-extended imm
// dsp_pc         in   DATA_W   instruction pc
// dsp_rob_pos    in   ROB_POS_W  destination ROB tag
// rs_full        out  1        registered; dispatcher must not assert dsp_valid while high
// alu_res_valid/alu_res_rob_pos/alu_res_val  in 1/ROB_POS_W/DATA_W  ALU broadcast
// lsb_res_valid/lsb_res_rob_pos/lsb_res_val  in 1/ROB_POS_W/DATA_W  LSB broadcast
// alu_en, alu_opcode, alu_func3, alu_func7, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
//                out  1/7/3/1/DATA_W x4/ROB_POS_W  registered issue to ALU
// BEHAVIOUR
// - Reset: all entries invalid; all outputs 0; rs_full=0.
// - rollback (sync, priority over all but rst): invalidate all entries; alu_en<=0; rs_full<=0.
// - rdy=0: no state or output change; dispatch and broadcasts ignored.
// - Alloc: dsp_valid writes lowest-index free entry; operands whose tag matches a same-cycle
//   broadcast are stored ready with the broadcast value (ALU broadcast wins if both match).
// - Wakeup: every valid entry with busy qN equal to a valid broadcast tag takes the value and clears busy.
// - Select: lowest-index entry whose operands are ready after this cycle's wakeup. The selected entry
//   drives alu_* regs with forwarded values, sets alu_en<=1, and frees the entry at the same edge.
//   With no candidate, alu_en<=0 and the other alu_* hold.
// - Latency: dispatch at edge N, operands ready -> alu_en high after edge N+1. Broadcast during
//   cycle M for the last pending operand -> issue at edge M+1.
// - Freed slot: reusable by dispatch from the next cycle; never in the same cycle as freeing.
// - rs_full<= (post-edge busy count >= RS_SIZE-1). This gives one slot of slack for registered dispatch.
// - dsp_valid while no free entry: op dropped; sim-only $error.
// - Tag compare applies only while busy; stale values are never overwritten.
// CONFIGURATION
// RS_ISSUE_BYPASS_EN defined: if no stored entry is ready and the dispatched op is fully ready
//   (including same-cycle forwarding), it issues to alu_* at edge N without allocating an entry.
//   The stored-entry priority is unchanged.
// Not defined: every op passes through an entry; minimum dispatch->alu_en latency is 2 edges.
// TESTING
// ADD x (val1=5,val2=7, ready) at N -> alu_en=1,opcode=0110011,val1=5,val2=7 after N+1 (N with bypass).
// Op with q1=3 busy; alu_res rob_pos=3 val=0x10 at M -> issue after M+1, alu_val1=0x10.
// Dispatch with q2=6 while lsb_res tag6 val=9 same cycle -> stored ready, issued val2=9.
// Fill RS_SIZE-1 non-ready entries -> rs_full=1; wake entry 2 -> issue, rs_full drops next edge.
// Two ready entries idx 1,4 -> idx1 issues first, idx4 next cycle.
// rollback with 5 pending entries -> alu_en=0, no issue afterwards; rdy=0 holds alu_* unchanged.

Source files
------------

// File: rtl/alu_reservation_station.sv
// Reservation station for the shared ALU: buffers dispatched ops, snoops ALU/LSB broadcasts, issues one ready op per cycle.
// Optional feature macro RS_ISSUE_BYPASS_EN: a fully-ready dispatched op may issue directly when no stored entry is ready.
module alu_reservation_station #(
    parameter int RS_SIZE   = 16,
    parameter int RS_IDX_W  = 4,
    parameter int ROB_POS_W = 4,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 dsp_valid,
    input  logic [6:0]           dsp_opcode,
    input  logic [2:0]           dsp_func3,
    input  logic                 dsp_func7,
    input  logic                 dsp_q1_busy,
    input  logic [ROB_POS_W-1:0] dsp_q1,
    input  logic [DATA_W-1:0]    dsp_val1,
    input  logic                 dsp_q2_busy,
    input  logic [ROB_POS_W-1:0] dsp_q2,
    input  logic [DATA_W-1:0]    dsp_val2,
    input  logic [DATA_W-1:0]    dsp_imm,
    input  logic [DATA_W-1:0]    dsp_pc,
    input  logic [ROB_POS_W-1:0] dsp_rob_pos,
    output logic                 rs_full,
    input  logic                 alu_res_valid,
    input  logic [ROB_POS_W-1:0] alu_res_rob_pos,
    input  logic [DATA_W-1:0]    alu_res_val,
    input  logic                 lsb_res_valid,
    input  logic [ROB_POS_W-1:0] lsb_res_rob_pos,
    input  logic [DATA_W-1:0]    lsb_res_val,
    output logic                 alu_en,
    output logic [6:0]           alu_opcode,
    output logic [2:0]           alu_func3,
    output logic                 alu_func7,
    output logic [DATA_W-1:0]    alu_val1,
    output logic [DATA_W-1:0]    alu_val2,
    output logic [DATA_W-1:0]    alu_imm,
    output logic [DATA_W-1:0]    alu_pc,
    output logic [ROB_POS_W-1:0] alu_rob_pos
);

    typedef struct packed {
        logic                 valid;
        logic [6:0]           opcode;
        logic [2:0]           func3;
        logic                 func7;
        logic                 q1_busy;
        logic [ROB_POS_W-1:0] q1;
        logic [DATA_W-1:0]    val1;
        logic                 q2_busy;
        logic [ROB_POS_W-1:0] q2;
        logic [DATA_W-1:0]    val2;
        logic [DATA_W-1:0]    imm;
        logic [DATA_W-1:0]    pc;
        logic [ROB_POS_W-1:0] rob_pos;
    } entry_t;

    entry_t ent   [RS_SIZE];
    entry_t woken [RS_SIZE];
    entry_t new_ent;
    entry_t issue_ent;

    logic [RS_SIZE-1:0]  ready_vec;
    logic                sel_found;
    logic [RS_IDX_W-1:0] sel_idx;
    logic                free_found;
    logic [RS_IDX_W-1:0] free_idx;
    logic                new_ready;
    logic                bypass;
    logic                do_alloc;
    int                  valid_cnt;
    int                  next_cnt;

    // Returns {busy, value}; the ALU broadcast wins when both sources carry the tag.
    function automatic logic [DATA_W:0] fwd(
        input logic                 busy,
        input logic [ROB_POS_W-1:0] q,
        input logic [DATA_W-1:0]    v,
        input logic                 a_vld,
        input logic [ROB_POS_W-1:0] a_pos,
        input logic [DATA_W-1:0]    a_val,
        input logic                 l_vld,
        input logic [ROB_POS_W-1:0] l_pos,
        input logic [DATA_W-1:0]    l_val
    );
        logic [DATA_W:0] r;
        r = {busy, v};
        if (busy && a_vld && a_pos == q)      r = {1'b0, a_val};
        else if (busy && l_vld && l_pos == q) r = {1'b0, l_val};
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            woken[i] = ent[i];
            {woken[i].q1_busy, woken[i].val1} = fwd(ent[i].q1_busy, ent[i].q1, ent[i].val1,
                alu_res_valid, alu_res_rob_pos, alu_res_val, lsb_res_valid, lsb_res_rob_pos, lsb_res_val);
            {woken[i].q2_busy, woken[i].val2} = fwd(ent[i].q2_busy, ent[i].q2, ent[i].val2,
                alu_res_valid, alu_res_rob_pos, alu_res_val, lsb_res_valid, lsb_res_rob_pos, lsb_res_val);
            ready_vec[i] = woken[i].valid && !woken[i].q1_busy && !woken[i].q2_busy;
        end
    end

    // Lowest-index ready entry and lowest-index free entry (free as of the start of the cycle).
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        valid_cnt  = 0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_found = 1'b1;
                sel_idx   = RS_IDX_W'(i);
            end
            if (!ent[i].valid) begin
                free_found = 1'b1;
                free_idx   = RS_IDX_W'(i);
            end
            valid_cnt = valid_cnt + (ent[i].valid ? 1 : 0);
        end
    end

    always_comb begin
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.opcode  = dsp_opcode;
        new_ent.func3   = dsp_func3;
        new_ent.func7   = dsp_func7;
        new_ent.q1      = dsp_q1;
        new_ent.q2      = dsp_q2;
        new_ent.imm     = dsp_imm;
        new_ent.pc      = dsp_pc;
        new_ent.rob_pos = dsp_rob_pos;
        {new_ent.q1_busy, new_ent.val1} = fwd(dsp_q1_busy, dsp_q1, dsp_val1,
            alu_res_valid, alu_res_rob_pos, alu_res_val, lsb_res_valid, lsb_res_rob_pos, lsb_res_val);
        {new_ent.q2_busy, new_ent.val2} = fwd(dsp_q2_busy, dsp_q2, dsp_val2,
            alu_res_valid, alu_res_rob_pos, alu_res_val, lsb_res_valid, lsb_res_rob_pos, lsb_res_val);
        new_ready = !new_ent.q1_busy && !new_ent.q2_busy;
    end

`ifdef RS_ISSUE_BYPASS_EN
    assign bypass = dsp_valid && !sel_found && new_ready;
`else
    assign bypass = 1'b0;
`endif

    assign do_alloc  = dsp_valid && free_found && !bypass;
    assign issue_ent = sel_found ? woken[sel_idx] : new_ent;
    assign next_cnt  = valid_cnt - (sel_found ? 1 : 0) + (do_alloc ? 1 : 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
            rs_full     <= 1'b0;
            alu_en      <= 1'b0;
            alu_opcode  <= '0;
            alu_func3   <= '0;
            alu_func7   <= 1'b0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_rob_pos <= '0;
        end else if (rollback) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i].valid <= 1'b0;
            rs_full <= 1'b0;
            alu_en  <= 1'b0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i] <= woken[i];
            if (sel_found) ent[sel_idx].valid <= 1'b0;
            // free_idx is never sel_idx: the selected entry was valid at the start of the cycle.
            if (do_alloc) ent[free_idx] <= new_ent;
            rs_full <= (next_cnt >= RS_SIZE - 1);
            alu_en  <= sel_found || bypass;
            if (sel_found || bypass) begin
                alu_opcode  <= issue_ent.opcode;
                alu_func3   <= issue_ent.func3;
                alu_func7   <= issue_ent.func7;
                alu_val1    <= issue_ent.val1;
                alu_val2    <= issue_ent.val2;
                alu_imm     <= issue_ent.imm;
                alu_pc      <= issue_ent.pc;
                alu_rob_pos <= issue_ent.rob_pos;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && !rollback && rdy && dsp_valid && !bypass && !free_found)
            $error("alu_reservation_station: dispatch with no free entry, op dropped");
    end
`endif

endmodule
